// File: rtl/instruction_execute.sv
// -----------------------------------------------------------------------------
// instruction_execute
//
// Execute stage of a five-stage MIPS pipeline. It takes the ID/EX contents,
// resolves operand forwarding, selects the destination register, computes the
// ALU result and registers everything that MEM/WB needs into the EX/MEM
// boundary.
//
// Build option:
//   EX_FORWARDING_EN  defined   -> operands A/B are forwarded from MEM/WB
//                     undefined -> A = i_RA, B = i_RB; i_fwd_* and i_rs unused
//
// Ports:
//   i_clk, i_reset (async, active low), i_enable (1 = advance, 0 = hold)
//   i_RA, i_RB            register-file operands
//   i_rs, i_rt, i_rd      register specifiers
//   i_funct, i_opcode     R-type function / instruction opcode
//   i_shamt, i_inmediato  shift amount / sign-extended immediate
//   i_EX_alu_src, i_EX_reg_dst, i_EX_alu_op   EX control
//   i_WB_*, i_MEM_*       control carried through to EX/MEM
//   i_fwd_MEM_*, i_fwd_WB_*  write enable, register and data of MEM and WB
//   o_alu_result, o_write_data, o_reg_dst      registered datapath results
//   o_WB_*, o_MEM_*       registered control
// -----------------------------------------------------------------------------
module instruction_execute #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_DATA-1:0] i_RA,
  input  logic [NB_DATA-1:0] i_RB,
  input  logic [NB_REG-1:0]  i_rs,
  input  logic [NB_REG-1:0]  i_rt,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic [5:0]         i_funct,
  input  logic [5:0]         i_opcode,
  input  logic [4:0]         i_shamt,
  input  logic [NB_DATA-1:0] i_inmediato,
  input  logic               i_EX_alu_src,
  input  logic               i_EX_reg_dst,
  input  logic [1:0]         i_EX_alu_op,
  input  logic               i_WB_write,
  input  logic               i_WB_mem_to_reg,
  input  logic               i_MEM_read,
  input  logic               i_MEM_write,
  input  logic               i_MEM_unsigned,
  input  logic [1:0]         i_MEM_byte_half_word,
  input  logic               i_fwd_MEM_write,
  input  logic               i_fwd_WB_write,
  input  logic [NB_REG-1:0]  i_fwd_MEM_reg,
  input  logic [NB_REG-1:0]  i_fwd_WB_reg,
  input  logic [NB_DATA-1:0] i_fwd_MEM_data,
  input  logic [NB_DATA-1:0] i_fwd_WB_data,
  output logic [NB_DATA-1:0] o_alu_result,
  output logic [NB_DATA-1:0] o_write_data,
  output logic [NB_REG-1:0]  o_reg_dst,
  output logic               o_WB_write,
  output logic               o_WB_mem_to_reg,
  output logic               o_MEM_read,
  output logic               o_MEM_write,
  output logic               o_MEM_unsigned,
  output logic [1:0]         o_MEM_byte_half_word
);

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Immediate-format opcodes
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  logic [NB_DATA-1:0] w_fwd_a;
  logic [NB_DATA-1:0] w_fwd_b;
  logic [NB_DATA-1:0] w_alu_b;
  logic [NB_DATA-1:0] w_alu_result;
  logic [NB_DATA-1:0] w_imm_zext;
  logic [NB_REG-1:0]  w_reg_dst;
  logic [4:0]         w_var_shamt;
  logic               w_lt_s;
  logic               w_lt_u;
  logic               w_lti_s;
  logic               w_lti_u;

  logic [NB_DATA-1:0] r_alu_result;
  logic [NB_DATA-1:0] r_write_data;
  logic [NB_REG-1:0]  r_reg_dst;
  logic               r_WB_write;
  logic               r_WB_mem_to_reg;
  logic               r_MEM_read;
  logic               r_MEM_write;
  logic               r_MEM_unsigned;
  logic [1:0]         r_MEM_byte_half_word;

`ifdef EX_FORWARDING_EN
  // Operand A forwarding: MEM beats WB, register 0 is never forwarded
  always_comb begin
    w_fwd_a = i_RA;
    if (i_fwd_MEM_write && (i_fwd_MEM_reg == i_rs) && (i_rs != {NB_REG{1'b0}})) begin
      w_fwd_a = i_fwd_MEM_data;
    end else if (i_fwd_WB_write && (i_fwd_WB_reg == i_rs) && (i_rs != {NB_REG{1'b0}})) begin
      w_fwd_a = i_fwd_WB_data;
    end else begin
      w_fwd_a = i_RA;
    end
  end

  // Operand B forwarding: same priority rules, keyed on rt
  always_comb begin
    w_fwd_b = i_RB;
    if (i_fwd_MEM_write && (i_fwd_MEM_reg == i_rt) && (i_rt != {NB_REG{1'b0}})) begin
      w_fwd_b = i_fwd_MEM_data;
    end else if (i_fwd_WB_write && (i_fwd_WB_reg == i_rt) && (i_rt != {NB_REG{1'b0}})) begin
      w_fwd_b = i_fwd_WB_data;
    end else begin
      w_fwd_b = i_RB;
    end
  end
`else
  // Hazards are resolved by stalling upstream, so operands come straight from ID
  assign w_fwd_a = i_RA;
  assign w_fwd_b = i_RB;

  // Forwarding inputs are intentionally left without a load in this build
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_rs, i_fwd_MEM_write, i_fwd_WB_write, i_fwd_MEM_reg,
                          i_fwd_WB_reg, i_fwd_MEM_data, i_fwd_WB_data};
`endif

  assign w_alu_b     = i_EX_alu_src ? i_inmediato : w_fwd_b;
  assign w_reg_dst   = i_EX_reg_dst ? i_rd : i_rt;
  assign w_var_shamt = w_fwd_a[4:0];
  assign w_imm_zext  = {{(NB_DATA-16){1'b0}}, i_inmediato[15:0]};
  assign w_lt_s      = $signed(w_fwd_a) < $signed(w_alu_b);
  assign w_lt_u      = w_fwd_a < w_alu_b;
  // Immediate compares use the sign-extended immediate for both flavours
  assign w_lti_s     = $signed(w_fwd_a) < $signed(i_inmediato);
  assign w_lti_u     = w_fwd_a < i_inmediato;

  // ALU: undefined funct/opcode encodings yield zero
  always_comb begin
    w_alu_result = {NB_DATA{1'b0}};
    case (i_EX_alu_op)
      2'b00: w_alu_result = w_fwd_a + w_alu_b;
      2'b01: w_alu_result = w_fwd_a - w_alu_b;
      2'b10: begin
        case (i_funct)
          FN_SLL:  w_alu_result = w_alu_b << i_shamt;
          FN_SRL:  w_alu_result = w_alu_b >> i_shamt;
          FN_SRA:  w_alu_result = $signed(w_alu_b) >>> i_shamt;
          FN_SLLV: w_alu_result = w_alu_b << w_var_shamt;
          FN_SRLV: w_alu_result = w_alu_b >> w_var_shamt;
          FN_SRAV: w_alu_result = $signed(w_alu_b) >>> w_var_shamt;
          FN_ADDU: w_alu_result = w_fwd_a + w_alu_b;
          FN_SUBU: w_alu_result = w_fwd_a - w_alu_b;
          FN_AND:  w_alu_result = w_fwd_a & w_alu_b;
          FN_OR:   w_alu_result = w_fwd_a | w_alu_b;
          FN_XOR:  w_alu_result = w_fwd_a ^ w_alu_b;
          FN_NOR:  w_alu_result = ~(w_fwd_a | w_alu_b);
          FN_SLT:  w_alu_result = {{(NB_DATA-1){1'b0}}, w_lt_s};
          FN_SLTU: w_alu_result = {{(NB_DATA-1){1'b0}}, w_lt_u};
          default: w_alu_result = {NB_DATA{1'b0}};
        endcase
      end
      2'b11: begin
        case (i_opcode)
          OP_ADDI:  w_alu_result = w_fwd_a + i_inmediato;
          OP_ADDIU: w_alu_result = w_fwd_a + i_inmediato;
          OP_SLTI:  w_alu_result = {{(NB_DATA-1){1'b0}}, w_lti_s};
          OP_SLTIU: w_alu_result = {{(NB_DATA-1){1'b0}}, w_lti_u};
          OP_ANDI:  w_alu_result = w_fwd_a & w_imm_zext;
          OP_ORI:   w_alu_result = w_fwd_a | w_imm_zext;
          OP_XORI:  w_alu_result = w_fwd_a ^ w_imm_zext;
          OP_LUI:   w_alu_result = {i_inmediato[15:0], {(NB_DATA-16){1'b0}}};
          default:  w_alu_result = {NB_DATA{1'b0}};
        endcase
      end
      default: w_alu_result = {NB_DATA{1'b0}};
    endcase
  end

  // EX/MEM boundary: reset clears to a bubble, i_enable=0 holds everything
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_alu_result         <= {NB_DATA{1'b0}};
      r_write_data         <= {NB_DATA{1'b0}};
      r_reg_dst            <= {NB_REG{1'b0}};
      r_WB_write           <= 1'b0;
      r_WB_mem_to_reg      <= 1'b0;
      r_MEM_read           <= 1'b0;
      r_MEM_write          <= 1'b0;
      r_MEM_unsigned       <= 1'b0;
      r_MEM_byte_half_word <= 2'b00;
    end else if (i_enable) begin
      r_alu_result         <= w_alu_result;
      r_write_data         <= w_fwd_b;
      r_reg_dst            <= w_reg_dst;
      r_WB_write           <= i_WB_write;
      r_WB_mem_to_reg      <= i_WB_mem_to_reg;
      r_MEM_read           <= i_MEM_read;
      r_MEM_write          <= i_MEM_write;
      r_MEM_unsigned       <= i_MEM_unsigned;
      r_MEM_byte_half_word <= i_MEM_byte_half_word;
    end
  end

  assign o_alu_result         = r_alu_result;
  assign o_write_data         = r_write_data;
  assign o_reg_dst            = r_reg_dst;
  assign o_WB_write           = r_WB_write;
  assign o_WB_mem_to_reg      = r_WB_mem_to_reg;
  assign o_MEM_read           = r_MEM_read;
  assign o_MEM_write          = r_MEM_write;
  assign o_MEM_unsigned       = r_MEM_unsigned;
  assign o_MEM_byte_half_word = r_MEM_byte_half_word;

endmodule

// File: tb/tb_instruction_execute.sv
// -----------------------------------------------------------------------------
// tb_instruction_execute
//
// Scoreboard bench for the execute stage. Each driven instruction pushes its
// expected EX/MEM contents; after the capturing edge the entry is popped and
// compared field by field. Expectations follow EX_FORWARDING_EN the same way
// the design does.
// -----------------------------------------------------------------------------
module tb_instruction_execute;

  typedef struct packed {
    logic        en;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        alu_src;
    logic        reg_dst;
    logic [1:0]  alu_op;
    logic [6:0]  ctrl;   // {WB_write, WB_mem_to_reg, MEM_read, MEM_write, MEM_unsigned, bhw[1:0]}
    logic        fmw;
    logic [4:0]  fmr;
    logic [31:0] fmd;
    logic        fww;
    logic [4:0]  fwr;
    logic [31:0] fwd;
  } stim_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] wdata;
    logic [4:0]  dst;
    logic [6:0]  ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en;
  logic [31:0] ra, rb, imm, fmd, fwdd;
  logic [4:0]  rs, rt, rd, shamt, fmr, fwr;
  logic [5:0]  funct, opcode;
  logic        alu_src, reg_dst, fmw, fww;
  logic [1:0]  alu_op;
  logic        wb_write, wb_m2r, mem_read, mem_write, mem_uns;
  logic [1:0]  bhw;

  logic [31:0] o_res, o_wdata;
  logic [4:0]  o_dst;
  logic        o_wb_write, o_wb_m2r, o_mem_read, o_mem_write, o_mem_uns;
  logic [1:0]  o_bhw;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t last_exp;

  always #5 clk = ~clk;

  instruction_execute #(.NB_DATA(32), .NB_REG(5)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_enable(en),
    .i_RA(ra), .i_RB(rb), .i_rs(rs), .i_rt(rt), .i_rd(rd),
    .i_funct(funct), .i_opcode(opcode), .i_shamt(shamt), .i_inmediato(imm),
    .i_EX_alu_src(alu_src), .i_EX_reg_dst(reg_dst), .i_EX_alu_op(alu_op),
    .i_WB_write(wb_write), .i_WB_mem_to_reg(wb_m2r), .i_MEM_read(mem_read),
    .i_MEM_write(mem_write), .i_MEM_unsigned(mem_uns), .i_MEM_byte_half_word(bhw),
    .i_fwd_MEM_write(fmw), .i_fwd_WB_write(fww), .i_fwd_MEM_reg(fmr),
    .i_fwd_WB_reg(fwr), .i_fwd_MEM_data(fmd), .i_fwd_WB_data(fwdd),
    .o_alu_result(o_res), .o_write_data(o_wdata), .o_reg_dst(o_dst),
    .o_WB_write(o_wb_write), .o_WB_mem_to_reg(o_wb_m2r), .o_MEM_read(o_mem_read),
    .o_MEM_write(o_mem_write), .o_MEM_unsigned(o_mem_uns), .o_MEM_byte_half_word(o_bhw)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Independent reference of the stage
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    logic [31:0] a, b, bb, r, zi;
    a = s.ra;
    b = s.rb;
`ifdef EX_FORWARDING_EN
    if (s.fmw && s.fmr == s.rs && s.rs != 5'd0)      a = s.fmd;
    else if (s.fww && s.fwr == s.rs && s.rs != 5'd0) a = s.fwd;
    if (s.fmw && s.fmr == s.rt && s.rt != 5'd0)      b = s.fmd;
    else if (s.fww && s.fwr == s.rt && s.rt != 5'd0) b = s.fwd;
`endif
    bb = s.alu_src ? s.imm : b;
    zi = {16'h0000, s.imm[15:0]};
    r  = 32'd0;
    if (s.alu_op == 2'b00) r = a + bb;
    else if (s.alu_op == 2'b01) r = a - bb;
    else if (s.alu_op == 2'b10) begin
      case (s.funct)
        6'h00: r = bb << s.shamt;
        6'h02: r = bb >> s.shamt;
        6'h03: r = 32'($signed(bb) >>> s.shamt);
        6'h04: r = bb << a[4:0];
        6'h06: r = bb >> a[4:0];
        6'h07: r = 32'($signed(bb) >>> a[4:0]);
        6'h21: r = a + bb;
        6'h23: r = a - bb;
        6'h24: r = a & bb;
        6'h25: r = a | bb;
        6'h26: r = a ^ bb;
        6'h27: r = ~(a | bb);
        6'h2A: r = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
        6'h2B: r = (a < bb) ? 32'd1 : 32'd0;
        default: r = 32'd0;
      endcase
    end else begin
      case (s.opcode)
        6'h08, 6'h09: r = a + s.imm;
        6'h0A: r = ($signed(a) < $signed(s.imm)) ? 32'd1 : 32'd0;
        6'h0B: r = (a < s.imm) ? 32'd1 : 32'd0;
        6'h0C: r = a & zi;
        6'h0D: r = a | zi;
        6'h0E: r = a ^ zi;
        6'h0F: r = {s.imm[15:0], 16'h0000};
        default: r = 32'd0;
      endcase
    end
    e.res   = r;
    e.wdata = b;
    e.dst   = s.reg_dst ? s.rd : s.rt;
    e.ctrl  = s.ctrl;
    return e;
  endfunction

  task automatic check_zero(input string tag);
    check_val({tag, ".res"},   o_res, 32'd0);
    check_val({tag, ".wdata"}, o_wdata, 32'd0);
    check_val({tag, ".dst"},   {27'd0, o_dst}, 32'd0);
    check_val({tag, ".ctrl"},  {25'd0, o_wb_write, o_wb_m2r, o_mem_read, o_mem_write, o_mem_uns, o_bhw}, 32'd0);
  endtask

  // Drive at the falling edge, push expectation, compare after the rising edge
  task automatic apply(input string tag, input stim_t s, input exp_t e);
    exp_t got;
    @(negedge clk);
    en = s.en; ra = s.ra; rb = s.rb; rs = s.rs; rt = s.rt; rd = s.rd;
    funct = s.funct; opcode = s.opcode; shamt = s.shamt; imm = s.imm;
    alu_src = s.alu_src; reg_dst = s.reg_dst; alu_op = s.alu_op;
    {wb_write, wb_m2r, mem_read, mem_write, mem_uns, bhw} = s.ctrl;
    fmw = s.fmw; fmr = s.fmr; fmd = s.fmd; fww = s.fww; fwr = s.fwr; fwdd = s.fwd;
    if (s.en) sb.push_back(e);
    else      sb.push_back(last_exp);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_val({tag, ".res"},   o_res, got.res);
    check_val({tag, ".wdata"}, o_wdata, got.wdata);
    check_val({tag, ".dst"},   {27'd0, o_dst}, {27'd0, got.dst});
    check_val({tag, ".ctrl"},  {25'd0, o_wb_write, o_wb_m2r, o_mem_read, o_mem_write, o_mem_uns, o_bhw},
              {25'd0, got.ctrl});
    last_exp = got;
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic [31:0] w,
                              input logic [4:0] d, input logic [6:0] c);
    exp_t e;
    e.res = r; e.wdata = w; e.dst = d; e.ctrl = c;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s, z;
    logic [5:0] fn_list [16];
    logic [5:0] op_list [9];
    fn_list = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F, 6'h20};
    op_list = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h00};
    z = '0;
    z.en = 1'b1;
    en = 1'b0; ra = '0; rb = '0; rs = '0; rt = '0; rd = '0; funct = '0; opcode = '0;
    shamt = '0; imm = '0; alu_src = 1'b0; reg_dst = 1'b0; alu_op = 2'b00;
    wb_write = 1'b0; wb_m2r = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_uns = 1'b0;
    bhw = 2'b00; fmw = 1'b0; fmr = '0; fmd = '0; fww = 1'b0; fwr = '0; fwdd = '0;
    last_exp = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // ADDU overflow wrap, destination rd
    s = z; s.alu_op = 2'b10; s.funct = 6'h21; s.ra = 32'h7FFF_FFFF; s.rb = 32'd1;
    s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd5; s.reg_dst = 1'b1; s.ctrl = 7'b1000000;
    apply("addu", s, mk(32'h8000_0000, 32'd1, 5'd5, 7'b1000000));

    // ORI zero-extends the immediate
    s = z; s.alu_op = 2'b11; s.opcode = 6'h0D; s.alu_src = 1'b1; s.ra = 32'h0001_0000;
    s.imm = 32'hFFFF_8000; s.rs = 5'd1; s.rt = 5'd6; s.ctrl = 7'b1000000;
    apply("ori", s, mk(32'h0001_8000, 32'd0, 5'd6, 7'b1000000));

    // LUI
    s = z; s.alu_op = 2'b11; s.opcode = 6'h0F; s.alu_src = 1'b1; s.imm = 32'h0000_1234;
    s.rt = 5'd7; s.ctrl = 7'b1000000;
    apply("lui", s, mk(32'h1234_0000, 32'd0, 5'd7, 7'b1000000));

    // Forwarding: MEM and WB both hit rs=3, MEM wins
    s = z; s.alu_op = 2'b10; s.funct = 6'h21; s.ra = 32'h11; s.rs = 5'd3; s.rt = 5'd4;
    s.fmw = 1'b1; s.fmr = 5'd3; s.fmd = 32'hAA; s.fww = 1'b1; s.fwr = 5'd3; s.fwd = 32'hBB;
`ifdef EX_FORWARDING_EN
    apply("fwd_mem", s, mk(32'hAA, 32'd0, 5'd4, 7'd0));
`else
    apply("fwd_mem", s, mk(32'h11, 32'd0, 5'd4, 7'd0));
`endif
    s.fmw = 1'b0;
`ifdef EX_FORWARDING_EN
    apply("fwd_wb", s, mk(32'hBB, 32'd0, 5'd4, 7'd0));
`else
    apply("fwd_wb", s, mk(32'h11, 32'd0, 5'd4, 7'd0));
`endif
    // Register 0 never forwarded
    s.rs = 5'd0; s.fmw = 1'b1; s.fmr = 5'd0; s.fwr = 5'd0;
    apply("fwd_r0", s, mk(32'h11, 32'd0, 5'd4, 7'd0));

    // SRAV shifts by A[4:0]
    s = z; s.alu_op = 2'b10; s.funct = 6'h07; s.ra = 32'h24; s.rb = 32'h8000_0000;
    s.rs = 5'd1; s.rt = 5'd2; s.rd = 5'd9; s.reg_dst = 1'b1;
    apply("srav", s, mk(32'hF800_0000, 32'h8000_0000, 5'd9, 7'd0));
    // SLT / SLTU of -1 vs 1
    s.funct = 6'h2A; s.ra = 32'hFFFF_FFFF; s.rb = 32'd1;
    apply("slt", s, mk(32'd1, 32'd1, 5'd9, 7'd0));
    s.funct = 6'h2B;
    apply("sltu", s, mk(32'd0, 32'd1, 5'd9, 7'd0));

    // Store: address add with immediate, store data forwarded from WB
    s = z; s.alu_op = 2'b00; s.alu_src = 1'b1; s.ra = 32'h100; s.imm = 32'd8;
    s.rs = 5'd2; s.rt = 5'd7; s.rb = 32'h5555; s.fww = 1'b1; s.fwr = 5'd7; s.fwd = 32'hDEAD;
    s.ctrl = 7'b0001011;
`ifdef EX_FORWARDING_EN
    apply("store", s, mk(32'h108, 32'hDEAD, 5'd7, 7'b0001011));
`else
    apply("store", s, mk(32'h108, 32'h5555, 5'd7, 7'b0001011));
`endif
    // Hold: different inputs, enable low
    s = z; s.en = 1'b0; s.alu_op = 2'b10; s.funct = 6'h25; s.ra = 32'h1234; s.rb = 32'h4321;
    s.rd = 5'd3; s.reg_dst = 1'b1; s.ctrl = 7'b1111111; s.fmw = 1'b1; s.fmr = 5'd0;
    apply("hold", s, mk(32'd0, 32'd0, 5'd0, 7'd0));

    // Randomised mix through the reference model
    for (int i = 0; i < 40; i++) begin
      s = z;
      s.en = ($urandom_range(0, 4) != 0);
      s.ra = $urandom(); s.rb = $urandom(); s.imm = $urandom();
      s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3)); s.rd = 5'($urandom());
      s.funct = fn_list[$urandom_range(0, 15)]; s.opcode = op_list[$urandom_range(0, 8)];
      s.shamt = 5'($urandom()); s.alu_src = 1'($urandom()); s.reg_dst = 1'($urandom());
      s.alu_op = 2'($urandom()); s.ctrl = 7'($urandom());
      s.fmw = 1'($urandom()); s.fmr = 5'($urandom_range(0, 3)); s.fmd = $urandom();
      s.fww = 1'($urandom()); s.fwr = 5'($urandom_range(0, 3)); s.fwd = $urandom();
      apply($sformatf("rnd%0d", i), s, model(s));
    end

    // Asynchronous reset mid-stream, between edges
    s = z; s.alu_op = 2'b01; s.ra = 32'h50; s.rb = 32'h8; s.rt = 5'd12; s.ctrl = 7'b1100100;
    apply("pre_rst", s, mk(32'h48, 32'h8, 5'd12, 7'b1100100));
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(posedge clk);
    #1 check_zero("rst_hold");
    @(negedge clk) en = 1'b0;
    rst_n = 1'b1;
    last_exp = '0;
    s.en = 1'b0;
    apply("post_rst_idle", s, mk(32'd0, 32'd0, 5'd0, 7'd0));
    s = z; s.alu_op = 2'b11; s.opcode = 6'h0C; s.alu_src = 1'b1; s.ra = 32'hFFFF_FFFF;
    s.imm = 32'hFFFF_0F0F; s.rt = 5'd13; s.ctrl = 7'b1000000;
    apply("post_rst_first", s, mk(32'h0000_0F0F, 32'd0, 5'd13, 7'b1000000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
